fwd_source_pipe: RTL and testbench

- Producer side of the EX-stage forwarding interface.
- Implements the EX/MEM and MEM/WB pipeline registers that source mem_rd/wb_rd, the reg-write qualifiers and the forwarded data.
- Also generates the load-use bubble request and the data-memory wait stall.
- Sits between the ALU/EX stage and the register-file write port; its outputs feed the forwarding unit and the write-back mux.

---
 rtl/fwd_source_pipe.sv | 160 ++++++++++++++++
 tb/tb_fwd_source_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_source_pipe.sv
// rtl/fwd_source_pipe.sv - EX/MEM and MEM/WB forwarding source registers with load-wait stall and load-use detect
// Optional FWD_STALL_CNT_EN adds a saturating stall-cycle counter output.
module fwd_source_pipe #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_WAIT       = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ex_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
    input  logic                      ex_reg_write_i,
    input  logic                      ex_mem_to_reg_i,
    input  logic [DATA_WIDTH-1:0]     ex_alu_result_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
    input  logic                      flush_i,
    input  logic                      mem_ready_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    output logic                      mem_req_o,
    output logic [DATA_WIDTH-1:0]     mem_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] mem_rd_o,
    output logic                      mem_reg_write_o,
    output logic [DATA_WIDTH-1:0]     mem_fwd_data_o,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd_o,
    output logic                      wb_reg_write_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    output logic                      stall_o,
    output logic                      load_use_o,
`ifdef FWD_STALL_CNT_EN
    output logic [31:0]               stall_cnt_o,
`endif
    output logic                      timeout_o
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;

    logic                      em_valid;
    logic                      em_load;
    logic                      em_rw;
    logic [REG_ADDR_WIDTH-1:0] em_rd;
    logic [DATA_WIDTH-1:0]     em_data;

    logic                      wb_rw;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0]     wb_data;

    logic                      wait_miss;
    logic                      last_wait;
    logic                      take;
    logic                      cap_rw;

    assign mem_req_o       = em_valid & em_load;
    assign mem_addr_o      = em_data;
    assign mem_rd_o        = em_rd;
    assign mem_reg_write_o = em_rw;
    assign mem_fwd_data_o  = em_data;
    assign wb_rd_o         = wb_rd;
    assign wb_reg_write_o  = wb_rw;
    assign wb_data_o       = wb_data;

    // The counter holds the number of cycles already stalled, so the final allowed
    // wait cycle releases the pipe instead of stalling again.
    assign wait_miss = mem_req_o & ~mem_ready_i;
    assign last_wait = (cnt_q == CW'(MAX_WAIT - 1));
    assign timeout_o = wait_miss & last_wait;
    assign stall_o   = wait_miss & ~last_wait;

    assign load_use_o = ex_valid_i & ex_mem_to_reg_i & ex_reg_write_i
                      & (ex_rd_i != '0)
                      & ((id_rs1_i == ex_rd_i) | (id_rs2_i == ex_rd_i));

    assign take   = ex_valid_i & ~flush_i;
    assign cap_rw = ex_reg_write_i & (ex_rd_i != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (stall_o) begin
                    state_d = S_WAIT;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (stall_o) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // While stalled EX/MEM keeps the load and WB gets a bubble, so the load writes back once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            em_valid <= 1'b0;
            em_load  <= 1'b0;
            em_rw    <= 1'b0;
            em_rd    <= '0;
            em_data  <= '0;
            wb_rw    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else if (stall_o) begin
            wb_rw    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            em_valid <= take;
            em_load  <= take & ex_mem_to_reg_i;
            em_rw    <= take & cap_rw;
            em_rd    <= (take & cap_rw) ? ex_rd_i : '0;
            em_data  <= take ? ex_alu_result_i : '0;
            wb_rw    <= em_rw;
            wb_rd    <= em_rd;
            if (em_load) begin
                wb_data <= timeout_o ? '0 : mem_rdata_i;
            end else begin
                wb_data <= em_data;
            end
        end
    end

`ifdef FWD_STALL_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_source_pipe.sv
// tb/tb_fwd_source_pipe.sv - self-checking bench for fwd_source_pipe
module tb_fwd_source_pipe;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          ex_valid_i, ex_reg_write_i, ex_mem_to_reg_i, flush_i, mem_ready_i;
    logic [AW-1:0] ex_rd_i, id_rs1_i, id_rs2_i;
    logic [DW-1:0] ex_alu_result_i, mem_rdata_i;
    logic          mem_req_o, mem_reg_write_o, wb_reg_write_o, stall_o, load_use_o, timeout_o;
    logic [AW-1:0] mem_rd_o, wb_rd_o;
    logic [DW-1:0] mem_addr_o, mem_fwd_data_o, wb_data_o;
`ifdef FWD_STALL_CNT_EN
    logic [31:0]   stall_cnt_o;
`endif

    fwd_source_pipe #(.REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ex_valid_i(ex_valid_i), .ex_rd_i(ex_rd_i), .ex_reg_write_i(ex_reg_write_i),
        .ex_mem_to_reg_i(ex_mem_to_reg_i), .ex_alu_result_i(ex_alu_result_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .flush_i(flush_i),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o),
        .mem_reg_write_o(mem_reg_write_o), .mem_fwd_data_o(mem_fwd_data_o),
        .wb_rd_o(wb_rd_o), .wb_reg_write_o(wb_reg_write_o), .wb_data_o(wb_data_o),
        .stall_o(stall_o), .load_use_o(load_use_o),
`ifdef FWD_STALL_CNT_EN
        .stall_cnt_o(stall_cnt_o),
`endif
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: one record for the instruction in MEM, one for the write-back slot,
    // and the number of cycles the MEM load has already waited.
    typedef struct packed {
        logic          v;
        logic          ld;
        logic          rw;
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
    } stage_t;

    stage_t m_mem, m_wb;
    int     m_wait;
    int     m_scnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic [AW-1:0] rd, input logic rw, input logic ld,
                          input logic [DW-1:0] alu, input logic [AW-1:0] rs1,
                          input logic [AW-1:0] rs2, input logic fl);
        ex_valid_i = v; ex_rd_i = rd; ex_reg_write_i = rw; ex_mem_to_reg_i = ld;
        ex_alu_result_i = alu; id_rs1_i = rs1; id_rs2_i = rs2; flush_i = fl;
    endtask

    task automatic idle();
        set_ex(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    // Compare every output with the reference, then advance both by one clock edge.
    task automatic cycle();
        logic   mreq, fire, stl, lu;
        stage_t nw, nm;
        #1;
        mreq = m_mem.v && m_mem.ld;
        fire = mreq && !mem_ready_i && (m_wait == MW - 1);
        stl  = mreq && !mem_ready_i && !fire;
        lu   = ex_valid_i && ex_mem_to_reg_i && ex_reg_write_i && (ex_rd_i != 0)
               && (id_rs1_i == ex_rd_i || id_rs2_i == ex_rd_i);
        chk("mem_req", mem_req_o, mreq);
        chk("mem_addr", mem_addr_o, m_mem.d);
        chk("mem_rd", mem_rd_o, m_mem.rd);
        chk("mem_rw", mem_reg_write_o, m_mem.rw);
        chk("mem_fwd", mem_fwd_data_o, m_mem.d);
        chk("wb_rd", wb_rd_o, m_wb.rd);
        chk("wb_rw", wb_reg_write_o, m_wb.rw);
        chk("wb_data", wb_data_o, m_wb.d);
        chk("stall", stall_o, stl);
        chk("timeout", timeout_o, fire);
        chk("load_use", load_use_o, lu);
`ifdef FWD_STALL_CNT_EN
        chk("stall_cnt", stall_cnt_o, m_scnt);
`endif
        if (rst_i) begin
            m_mem = '0; m_wb = '0; m_wait = 0; m_scnt = 0;
        end else if (stl) begin
            m_wb = '0; m_wait++; m_scnt++;
        end else begin
            nw    = '0;
            nw.rw = m_mem.rw;
            nw.rd = m_mem.rd;
            nw.d  = m_mem.ld ? (fire ? '0 : mem_rdata_i) : m_mem.d;
            nm    = '0;
            if (ex_valid_i && !flush_i) begin
                nm.v  = 1'b1;
                nm.ld = ex_mem_to_reg_i;
                nm.rw = ex_reg_write_i && (ex_rd_i != 0);
                nm.rd = nm.rw ? ex_rd_i : '0;
                nm.d  = ex_alu_result_i;
            end
            m_wb = nw; m_mem = nm; m_wait = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_i = 1'b1; mem_ready_i = 1'b0; mem_rdata_i = '0;
        idle();
        m_mem = '0; m_wb = '0; m_wait = 0; m_scnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_rd", mem_rd_o, 0);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_timeout", timeout_o, 0);

        // Back-to-back ALU ops
        set_ex(1'b1, 5'd3, 1'b1, 1'b0, 32'h11, '0, '0, 1'b0);
        cycle();
        chk("a_mem_rd", mem_rd_o, 3);
        chk("a_mem_fwd", mem_fwd_data_o, 32'h11);
        set_ex(1'b1, 5'd4, 1'b1, 1'b0, 32'h22, '0, '0, 1'b0);
        cycle();
        chk("a_wb_rd", wb_rd_o, 3);
        chk("a_wb_data", wb_data_o, 32'h11);
        chk("a_mem_rd2", mem_rd_o, 4);
        idle();
        cycle();
        cycle();

        // Load with three wait cycles
        set_ex(1'b1, 5'd5, 1'b1, 1'b1, 32'h100, '0, '0, 1'b0);
        cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            mem_ready_i = 1'b0;
            #1;
            chk("b_stall", stall_o, 1);
            chk("b_addr", mem_addr_o, 32'h100);
            chk("b_wb_rw", wb_reg_write_o, 0);
            cycle();
        end
        mem_ready_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        #1;
        chk("b_release", stall_o, 0);
        cycle();
        chk("b_wb_rd", wb_rd_o, 5);
        chk("b_wb_data", wb_data_o, 32'hDEADBEEF);
        chk("b_wb_rw1", wb_reg_write_o, 1);
        mem_ready_i = 1'b0;
        cycle();
        chk("b_once", wb_reg_write_o, 0);
`ifdef FWD_STALL_CNT_EN
        chk("b_stall_cnt", stall_cnt_o, 3);
`endif

        // Load-use detection
        set_ex(1'b1, 5'd7, 1'b1, 1'b1, 32'h0, 5'd1, 5'd7, 1'b0);
        #1; chk("c_lu_hit", load_use_o, 1);
        set_ex(1'b1, 5'd0, 1'b1, 1'b1, 32'h0, 5'd0, 5'd0, 1'b0);
        #1; chk("c_lu_x0", load_use_o, 0);
        set_ex(1'b1, 5'd7, 1'b1, 1'b1, 32'h0, 5'd8, 5'd8, 1'b0);
        #1; chk("c_lu_miss", load_use_o, 0);
        idle();

        // Flush and x0 normalization
        set_ex(1'b1, 5'd9, 1'b1, 1'b0, 32'h99, '0, '0, 1'b1);
        cycle();
        chk("d_flush_rw", mem_reg_write_o, 0);
        chk("d_flush_rd", mem_rd_o, 0);
        set_ex(1'b1, 5'd0, 1'b1, 1'b0, 32'h55, '0, '0, 1'b0);
        cycle();
        chk("d_x0_rw", mem_reg_write_o, 0);
        idle();
        cycle();

        // Load timeout
        set_ex(1'b1, 5'd6, 1'b1, 1'b1, 32'h200, '0, '0, 1'b0);
        cycle();
        idle();
        mem_ready_i = 1'b0; mem_rdata_i = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("e_stall", stall_o, 1);
            chk("e_no_to", timeout_o, 0);
            cycle();
        end
        #1;
        chk("e_timeout", timeout_o, 1);
        chk("e_stall_off", stall_o, 0);
        cycle();
        chk("e_wb_rd", wb_rd_o, 6);
        chk("e_wb_data", wb_data_o, 0);
        chk("e_wb_rw", wb_reg_write_o, 1);
        cycle();

        // Reset while waiting
        set_ex(1'b1, 5'd6, 1'b1, 1'b1, 32'h300, '0, '0, 1'b0);
        cycle();
        idle();
        cycle();
        cycle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        #1;
        chk("f_mem_req", mem_req_o, 0);
        chk("f_stall", stall_o, 0);
        chk("f_timeout", timeout_o, 0);
        chk("f_mem_addr", mem_addr_o, 0);
        chk("f_wb_rw", wb_reg_write_o, 0);
`ifdef FWD_STALL_CNT_EN
        chk("f_stall_cnt", stall_cnt_o, 0);
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            set_ex($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 1'($urandom),
                   $urandom_range(0, 2) == 0, $urandom, 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
            mem_ready_i = $urandom_range(0, 2) == 0;
            mem_rdata_i = $urandom;
            rst_i       = $urandom_range(0, 99) == 0;
            cycle();
        end
        rst_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
